// File: rtl/wordle_guess_engine_if.sv
// Purpose : button / word / result bundle between the Wordle guess engine and
//           its surrounding board logic.
// Ports   : master drives the debounced buttons and the secret word;
//           slave (the engine) drives guess display, cursor, row, result and
//           status flags.
interface wordle_guess_engine_if;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        btn_submit;
  logic [24:0] target_word;
  logic [24:0] guess_letters;
  logic [2:0]  cursor;
  logic [2:0]  row;
  logic [9:0]  result;
  logic        result_valid;
  logic [2:0]  result_row;
  logic        busy;
  logic        win;
  logic        lose;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_submit, target_word,
    input  guess_letters, cursor, row, result, result_valid, result_row,
           busy, win, lose
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_submit, target_word,
    output guess_letters, cursor, row, result, result_valid, result_row,
           busy, win, lose
  );
endinterface

// File: rtl/wordle_guess_engine.sv
// Purpose : Wordle guess entry and evaluation engine. Letters are edited with
//           up/down/left/right buttons, submitted, then scored green/yellow/
//           gray against a latched secret word over seven cycles.
// Ports   : board_clk   - system clock, rising edge
//           reset       - asynchronous active-high reset
//           bus (slave) - buttons and target_word in; guess_letters, cursor,
//                         row, result, result_valid, result_row, busy, win,
//                         lose out (all registered)
module wordle_guess_engine (
  input  logic                  board_clk,
  input  logic                  reset,
  wordle_guess_engine_if.slave  bus
);

  localparam int unsigned LW         = 5;   // bits per letter
  localparam int unsigned NPOS       = 5;   // letters per word
  localparam int unsigned WW         = 25;  // word width
  localparam int unsigned RW         = 10;  // result width
  localparam logic [4:0]  MAX_LETTER = 5'd25;
  localparam logic [2:0]  LAST_POS   = 3'd4;
  localparam logic [2:0]  LAST_ROW   = 3'd5;

  localparam logic [1:0]  C_GREEN    = 2'b10;
  localparam logic [1:0]  C_YELLOW   = 2'b01;
  localparam logic [9:0]  ALL_GREEN  = 10'b10_10_10_10_10;

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_ENTRY  = 3'd1;
  localparam logic [2:0] S_EVAL_G = 3'd2;
  localparam logic [2:0] S_EVAL_Y = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;
  localparam logic [2:0] S_WIN    = 3'd5;
  localparam logic [2:0] S_LOSE   = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [WW-1:0]   letters_q, letters_d;
  logic [2:0]      cursor_q, cursor_d;
  logic [2:0]      row_q, row_d;
  logic [RW-1:0]   result_q, result_d;
  logic            result_valid_q, result_valid_d;
  logic [2:0]      result_row_q, result_row_d;
  logic            busy_q, busy_d;
  logic            win_q, win_d;
  logic            lose_q, lose_d;
  logic [WW-1:0]   target_q, target_d;
  logic [WW-1:0]   eval_guess_q, eval_guess_d;
  logic [RW-1:0]   eval_res_q, eval_res_d;
  logic [NPOS-1:0] used_q, used_d;
  logic [2:0]      idx_q, idx_d;

  logic [4:0]      cur_lsb;
  logic [4:0]      cur_letter;
  logic [4:0]      idx_lsb;
  logic [3:0]      res_lsb;
  logic [4:0]      guess_letter;
  logic            found;

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d        = state_q;
    letters_d      = letters_q;
    cursor_d       = cursor_q;
    row_d          = row_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    result_row_d   = result_row_q;
    target_d       = target_q;
    eval_guess_d   = eval_guess_q;
    eval_res_d     = eval_res_q;
    used_d         = used_q;
    idx_d          = idx_q;
    found          = 1'b0;
    cur_lsb        = 5'(cursor_q) * 5'(LW);
    cur_letter     = letters_q[cur_lsb +: LW];
    idx_lsb        = 5'(idx_q) * 5'(LW);
    res_lsb        = {idx_q, 1'b0};
    guess_letter   = eval_guess_q[idx_lsb +: LW];

    case (state_q)
      S_INIT: begin
        target_d     = bus.target_word;
        letters_d    = '0;
        cursor_d     = '0;
        row_d        = '0;
        result_d     = '0;
        result_row_d = '0;
        eval_res_d   = '0;
        used_d       = '0;
        idx_d        = '0;
        state_d      = S_ENTRY;
      end

      // One button per cycle: submit > up > down > left > right
      S_ENTRY: begin
        if (bus.btn_submit) begin
          eval_guess_d = letters_q;
          eval_res_d   = '0;
          used_d       = '0;
          idx_d        = '0;
          state_d      = S_EVAL_G;
        end else if (bus.btn_up) begin
          letters_d[cur_lsb +: LW] = (cur_letter == MAX_LETTER) ? 5'd0 : cur_letter + 5'd1;
        end else if (bus.btn_down) begin
          letters_d[cur_lsb +: LW] = (cur_letter == 5'd0) ? MAX_LETTER : cur_letter - 5'd1;
        end else if (bus.btn_left) begin
          if (cursor_q != 3'd0) cursor_d = cursor_q - 3'd1;
        end else if (bus.btn_right) begin
          if (cursor_q != LAST_POS) cursor_d = cursor_q + 3'd1;
        end
      end

      // Greens first so yellows can never claim a target letter a green owns
      S_EVAL_G: begin
        for (int i = 0; i < NPOS; i++) begin
          if (eval_guess_q[i*LW +: LW] == target_q[i*LW +: LW]) begin
            eval_res_d[i*2 +: 2] = C_GREEN;
            used_d[i]            = 1'b1;
          end
        end
        idx_d   = '0;
        state_d = S_EVAL_Y;
      end

      // One guess position per cycle; lowest unused matching target letter wins
      S_EVAL_Y: begin
        if (eval_res_q[res_lsb +: 2] != C_GREEN) begin
          for (int j = 0; j < NPOS; j++) begin
            if (!found && !used_q[j] && (target_q[j*LW +: LW] == guess_letter)) begin
              found     = 1'b1;
              used_d[j] = 1'b1;
            end
          end
          if (found) eval_res_d[res_lsb +: 2] = C_YELLOW;
        end
        if (idx_q == LAST_POS) begin
          result_d       = eval_res_d;
          result_row_d   = row_q;
          result_valid_d = 1'b1;
          state_d        = S_REPORT;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end

      S_REPORT: begin
        if (eval_res_q == ALL_GREEN) begin
          state_d = S_WIN;
        end else if (row_q == LAST_ROW) begin
          state_d = S_LOSE;
        end else begin
          row_d     = row_q + 3'd1;
          letters_d = '0;
          cursor_d  = '0;
          state_d   = S_ENTRY;
        end
      end

      S_WIN, S_LOSE: begin
        if (bus.btn_submit) state_d = S_INIT;
      end

      default: state_d = S_INIT;
    endcase

    // Status flags track the state being entered so they align with it
    busy_d = (state_d == S_EVAL_G) || (state_d == S_EVAL_Y) || (state_d == S_REPORT);
    win_d  = (state_d == S_WIN);
    lose_d = (state_d == S_LOSE);
  end

  // State and output registers
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_INIT;
      letters_q      <= '0;
      cursor_q       <= '0;
      row_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      result_row_q   <= '0;
      busy_q         <= 1'b0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
      target_q       <= '0;
      eval_guess_q   <= '0;
      eval_res_q     <= '0;
      used_q         <= '0;
      idx_q          <= '0;
    end else begin
      state_q        <= state_d;
      letters_q      <= letters_d;
      cursor_q       <= cursor_d;
      row_q          <= row_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      result_row_q   <= result_row_d;
      busy_q         <= busy_d;
      win_q          <= win_d;
      lose_q         <= lose_d;
      target_q       <= target_d;
      eval_guess_q   <= eval_guess_d;
      eval_res_q     <= eval_res_d;
      used_q         <= used_d;
      idx_q          <= idx_d;
    end
  end

  assign bus.guess_letters = letters_q;
  assign bus.cursor        = cursor_q;
  assign bus.row           = row_q;
  assign bus.result        = result_q;
  assign bus.result_valid  = result_valid_q;
  assign bus.result_row    = result_row_q;
  assign bus.busy          = busy_q;
  assign bus.win           = win_q;
  assign bus.lose          = lose_q;

endmodule

// File: tb/tb_wordle_guess_engine.sv
// Purpose : directed self-checking bench for wordle_guess_engine.
// Ports   : none (top-level bench); drives the engine through its interface.
module tb_wordle_guess_engine;

  logic board_clk;
  logic reset;
  int   n_vec;
  int   n_err;

  wordle_guess_engine_if bus ();

  wordle_guess_engine dut (
    .board_clk (board_clk),
    .reset     (reset),
    .bus       (bus)
  );

  localparam logic [24:0] W_CRANE = {5'd4, 5'd13, 5'd0, 5'd17, 5'd2};
  localparam logic [24:0] W_EERIE = {5'd4, 5'd8, 5'd17, 5'd4, 5'd4};
  localparam logic [24:0] W_AAAAA = 25'd0;

  initial board_clk = 1'b0;
  always #5 board_clk = ~board_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge board_clk);
    #1;
  endtask

  // b = {submit, up, down, left, right}
  task automatic press(input logic [4:0] b);
    bus.btn_submit = b[4];
    bus.btn_up     = b[3];
    bus.btn_down   = b[2];
    bus.btn_left   = b[1];
    bus.btn_right  = b[0];
    tick();
    bus.btn_submit = 1'b0;
    bus.btn_up     = 1'b0;
    bus.btn_down   = 1'b0;
    bus.btn_left   = 1'b0;
    bus.btn_right  = 1'b0;
  endtask

  // Assumes cursor 0 and all letters 0 on entry
  task automatic enter_word(input logic [24:0] w);
    logic [4:0] l;
    for (int p = 0; p < 5; p++) begin
      l = w[p*5 +: 5];
      for (int k = 0; k < int'(l); k++) press(5'b01000);
      if (p < 4) press(5'b00001);
    end
    check_eq("entered_word", 32'(bus.guess_letters), 32'(w));
  endtask

  task automatic submit_check(input logic [9:0] exp_res, input logic [2:0] exp_row,
                              input logic [24:0] exp_guess);
    int c;
    press(5'b10000);
    c = 1;
    check_eq("busy_first_eval", 32'(bus.busy), 32'd1);
    while (!bus.result_valid && c < 20) begin
      tick();
      c++;
      if (c == 4) check_eq("guess_held_in_eval", 32'(bus.guess_letters), 32'(exp_guess));
    end
    check_eq("result_latency", 32'(c), 32'd7);
    check_eq("result", 32'(bus.result), 32'(exp_res));
    check_eq("result_row", 32'(bus.result_row), 32'(exp_row));
    check_eq("busy_in_report", 32'(bus.busy), 32'd1);
    tick();
    check_eq("result_valid_pulse", 32'(bus.result_valid), 32'd0);
    check_eq("result_hold", 32'(bus.result), 32'(exp_res));
    check_eq("busy_after_report", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_guess"}, 32'(bus.guess_letters), 32'd0);
    check_eq({tag, "_cursor"}, 32'(bus.cursor), 32'd0);
    check_eq({tag, "_row"}, 32'(bus.row), 32'd0);
    check_eq({tag, "_result"}, 32'(bus.result), 32'd0);
    check_eq({tag, "_rvalid"}, 32'(bus.result_valid), 32'd0);
    check_eq({tag, "_rrow"}, 32'(bus.result_row), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_win"}, 32'(bus.win), 32'd0);
    check_eq({tag, "_lose"}, 32'(bus.lose), 32'd0);
  endtask

  initial begin
    int pulses;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.btn_submit = 1'b0;
    bus.btn_up     = 1'b0;
    bus.btn_down   = 1'b0;
    bus.btn_left   = 1'b0;
    bus.btn_right  = 1'b0;
    bus.target_word = W_CRANE;
    #1;
    tick();
    tick();
    check_all_zero("reset");

    // Release with btn_up held: INIT must swallow it
    reset = 1'b0;
    bus.btn_up = 1'b1;
    tick();
    bus.btn_up = 1'b0;
    check_eq("init_ignores_btn", 32'(bus.guess_letters), 32'd0);

    // Target register must be used, not the live input
    bus.target_word = 25'h1FFFFFF;

    // Letter and cursor bounds
    press(5'b00100);
    check_eq("down_wrap", 32'(bus.guess_letters[4:0]), 32'd25);
    press(5'b01000);
    check_eq("up_wrap", 32'(bus.guess_letters[4:0]), 32'd0);
    press(5'b00010);
    check_eq("left_sat", 32'(bus.cursor), 32'd0);
    for (int k = 0; k < 6; k++) press(5'b00001);
    check_eq("right_sat", 32'(bus.cursor), 32'd4);
    press(5'b01010);
    check_eq("up_left_letter", 32'(bus.guess_letters), 32'(25'd1 << 20));
    check_eq("up_left_cursor", 32'(bus.cursor), 32'd4);
    press(5'b00100);
    for (int k = 0; k < 4; k++) press(5'b00010);
    check_eq("back_home", 32'(bus.cursor), 32'd0);

    // AAAAA vs CRANE, then EERIE vs CRANE
    submit_check(10'b00_00_10_00_00, 3'd0, W_AAAAA);
    check_eq("row_after_1", 32'(bus.row), 32'd1);
    enter_word(W_EERIE);
    for (int k = 0; k < 4; k++) press(5'b00010);
    submit_check(10'b10_00_01_00_00, 3'd1, W_EERIE);
    check_eq("letters_cleared", 32'(bus.guess_letters), 32'd0);

    // Reset mid-evaluation (N+4) aborts without a result pulse
    bus.target_word = W_CRANE;
    press(5'b10000);
    tick();
    tick();
    tick();
    reset = 1'b1;
    pulses = 0;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (bus.result_valid) pulses++;
      tick();
    end
    check_all_zero("abort_reset");
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (bus.result_valid) pulses++;
      if (k == 0) tick(); else tick();
    end
    check_eq("abort_no_pulse", 32'(pulses), 32'd0);
    check_all_zero("abort_release");
    press(5'b01000);
    check_eq("abort_in_entry", 32'(bus.guess_letters), 32'd1);
    press(5'b00100);

    // Six wrong guesses lead to LOSE
    for (int r = 0; r < 6; r++) submit_check(10'b00_00_10_00_00, 3'(r), W_AAAAA);
    check_eq("lose_flag", 32'(bus.lose), 32'd1);
    check_eq("lose_row", 32'(bus.row), 32'd5);
    press(5'b01000);
    check_eq("lose_ignores_up", 32'(bus.guess_letters), 32'd0);
    press(5'b10000);
    tick();
    check_eq("new_game_row", 32'(bus.row), 32'd0);
    check_eq("new_game_lose", 32'(bus.lose), 32'd0);

    // Winning guess
    enter_word(W_CRANE);
    for (int k = 0; k < 4; k++) press(5'b00010);
    submit_check(10'b10_10_10_10_10, 3'd0, W_CRANE);
    check_eq("win_flag", 32'(bus.win), 32'd1);
    press(5'b01000);
    check_eq("win_ignores_up", 32'(bus.guess_letters), 32'(W_CRANE));
    press(5'b10000);
    tick();
    check_eq("win_restart_row", 32'(bus.row), 32'd0);
    check_eq("win_restart_flag", 32'(bus.win), 32'd0);
    check_eq("win_restart_guess", 32'(bus.guess_letters), 32'd0);
    press(5'b01000);
    check_eq("win_restart_entry", 32'(bus.guess_letters), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
